// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the DDR3 burst arbiter.
// The FSM encoding, default channel counts and pointer width all live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_BUSY = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  localparam int DEF_RD_CH = 2;
  localparam int DEF_WR_CH = 2;
  localparam int CH_NUM    = DEF_RD_CH + DEF_WR_CH;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_BITS = ptr_bits(CH_NUM);

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after last_ptr_i,
// found by searching a doubled request vector so the wrap-around needs no special case.
module mem_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] last_ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl     = {req_i, req_i};
    masked  = '0;
    found_o = 1'b0;
    idx_o   = '0;
    // Window of exactly one lap: positions last_ptr+1 .. last_ptr+N.
    for (int k = 0; k < 2*N; k++) begin
      masked[k] = dbl[k] && (k > int'(last_ptr_i)) && (k <= int'(last_ptr_i) + N);
    end
    for (int k = 2*N-1; k >= 0; k--) begin
      if (masked[k]) begin
        found_o = 1'b1;
        idx_o   = PW'((k >= N) ? (k - N) : k);
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller burst port among several
// read and write frame-buffer channels, with a sticky beat/length mismatch flag.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 25,
  parameter int BUSRT_BITS    = 10,
  parameter int RD_CH         = DEF_RD_CH,
  parameter int WR_CH         = DEF_WR_CH,
  localparam int NCH          = RD_CH + WR_CH,
  localparam int GW           = ptr_bits(NCH)
) (
  input  logic                           mem_clk,
  input  logic                           rst_n,
  input  logic [RD_CH-1:0]               ch_rd_burst_req,
  input  logic [RD_CH*BUSRT_BITS-1:0]    ch_rd_burst_len,
  input  logic [RD_CH*ADDR_BITS-1:0]     ch_rd_burst_addr,
  output logic [RD_CH-1:0]               ch_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]       ch_rd_burst_data,
  output logic [RD_CH-1:0]               ch_rd_burst_finish,
  input  logic [WR_CH-1:0]               ch_wr_burst_req,
  input  logic [WR_CH*BUSRT_BITS-1:0]    ch_wr_burst_len,
  input  logic [WR_CH*ADDR_BITS-1:0]     ch_wr_burst_addr,
  output logic [WR_CH-1:0]               ch_wr_burst_data_req,
  input  logic [WR_CH*MEM_DATA_BITS-1:0] ch_wr_burst_data,
  output logic [WR_CH-1:0]               ch_wr_burst_finish,
  output logic                           rd_burst_req,
  output logic [BUSRT_BITS-1:0]          rd_burst_len,
  output logic [ADDR_BITS-1:0]           rd_burst_addr,
  input  logic                           rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]       rd_burst_data,
  input  logic                           rd_burst_finish,
  output logic                           wr_burst_req,
  output logic [BUSRT_BITS-1:0]          wr_burst_len,
  output logic [ADDR_BITS-1:0]           wr_burst_addr,
  input  logic                           wr_burst_data_req,
  input  logic                           wr_burst_finish,
  output logic [MEM_DATA_BITS-1:0]       wr_burst_data,
  output logic [GW-1:0]                  grant_id,
  output logic                           len_err
);

  arb_state_t              state_q, state_d;
  logic                    rd_req_q, rd_req_d;
  logic                    wr_req_q, wr_req_d;
  logic [BUSRT_BITS-1:0]   len_q, len_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [BUSRT_BITS:0]     beat_q, beat_d;
  logic                    err_q, err_d;

  logic [NCH-1:0]          req_vec;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic [BUSRT_BITS-1:0]   pick_len;
  logic [ADDR_BITS-1:0]    pick_addr;
  logic                    beat_inc;
  logic [BUSRT_BITS:0]     beat_now;

  assign req_vec = {ch_wr_burst_req, ch_rd_burst_req};

  mem_rr_pick #(.N(NCH), .PW(GW)) u_pick (
    .req_i      (req_vec),
    .last_ptr_i (last_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  always_comb begin
    pick_len  = '0;
    pick_addr = '0;
    for (int i = 0; i < RD_CH; i++) begin
      if (int'(pick_idx) == i) begin
        pick_len  = ch_rd_burst_len[i*BUSRT_BITS +: BUSRT_BITS];
        pick_addr = ch_rd_burst_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
    for (int i = 0; i < WR_CH; i++) begin
      if (int'(pick_idx) == RD_CH + i) begin
        pick_len  = ch_wr_burst_len[i*BUSRT_BITS +: BUSRT_BITS];
        pick_addr = ch_wr_burst_addr[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  // The finish cycle's own beat is included so a controller that flags
  // finish together with its last beat is still counted correctly.
  assign beat_inc = ((state_q == RD_BUSY) && rd_burst_data_valid) ||
                    ((state_q == WR_BUSY) && wr_burst_data_req);
  assign beat_now = beat_q + (BUSRT_BITS+1)'(beat_inc);

  always_comb begin
    state_d  = state_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    len_d    = len_q;
    addr_d   = addr_q;
    grant_d  = grant_q;
    last_d   = last_q;
    beat_d   = beat_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          len_d   = pick_len;
          addr_d  = pick_addr;
          beat_d  = '0;
          if (int'(pick_idx) < RD_CH) begin
            rd_req_d = 1'b1;
            state_d  = RD_BUSY;
          end else begin
            wr_req_d = 1'b1;
            state_d  = WR_BUSY;
          end
        end
      end
      RD_BUSY: begin
        beat_d = beat_now;
        if (rd_burst_finish) begin
          rd_req_d = 1'b0;
          state_d  = GAP;
          if (beat_now != {1'b0, len_q}) err_d = 1'b1;
        end
      end
      WR_BUSY: begin
        beat_d = beat_now;
        if (wr_burst_finish) begin
          wr_req_d = 1'b0;
          state_d  = GAP;
          if (beat_now != {1'b0, len_q}) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      grant_q  <= '0;
      last_q   <= GW'(NCH - 1);
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Responses are steered only while a burst is actually in flight.
  always_comb begin
    ch_rd_burst_data_valid = '0;
    ch_rd_burst_finish     = '0;
    ch_wr_burst_data_req   = '0;
    ch_wr_burst_finish     = '0;
    wr_burst_data          = '0;
    for (int i = 0; i < RD_CH; i++) begin
      if ((state_q == RD_BUSY) && (int'(grant_q) == i)) begin
        ch_rd_burst_data_valid[i] = rd_burst_data_valid;
        ch_rd_burst_finish[i]     = rd_burst_finish;
      end
    end
    for (int i = 0; i < WR_CH; i++) begin
      if (int'(grant_q) == RD_CH + i) begin
        if (state_q == WR_BUSY) begin
          ch_wr_burst_data_req[i] = wr_burst_data_req;
          ch_wr_burst_finish[i]   = wr_burst_finish;
        end
        if (state_q != IDLE) wr_burst_data = ch_wr_burst_data[i*MEM_DATA_BITS +: MEM_DATA_BITS];
      end
    end
  end

  assign ch_rd_burst_data = rd_burst_data;
  assign rd_burst_req     = rd_req_q;
  assign rd_burst_len     = len_q;
  assign rd_burst_addr    = addr_q;
  assign wr_burst_req     = wr_req_q;
  assign wr_burst_len     = len_q;
  assign wr_burst_addr    = addr_q;
  assign grant_id         = grant_q;
  assign len_err          = err_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomized bench for mem_burst_arbiter: acts as both the channels and the
// DDR3 controller, predicting grants with a plain round-robin model.
module tb_mem_burst_arbiter;

  localparam int D  = 64;
  localparam int A  = 25;
  localparam int B  = 10;
  localparam int RD = 2;
  localparam int WR = 2;
  localparam int N  = RD + WR;

  logic mem_clk = 1'b0;
  logic rst_n   = 1'b0;

  logic [RD-1:0]   ch_rd_burst_req;
  logic [RD*B-1:0] ch_rd_burst_len;
  logic [RD*A-1:0] ch_rd_burst_addr;
  logic [RD-1:0]   ch_rd_burst_data_valid;
  logic [D-1:0]    ch_rd_burst_data;
  logic [RD-1:0]   ch_rd_burst_finish;
  logic [WR-1:0]   ch_wr_burst_req;
  logic [WR*B-1:0] ch_wr_burst_len;
  logic [WR*A-1:0] ch_wr_burst_addr;
  logic [WR-1:0]   ch_wr_burst_data_req;
  logic [WR*D-1:0] ch_wr_burst_data;
  logic [WR-1:0]   ch_wr_burst_finish;
  logic            rd_burst_req;
  logic [B-1:0]    rd_burst_len;
  logic [A-1:0]    rd_burst_addr;
  logic            rd_burst_data_valid;
  logic [D-1:0]    rd_burst_data;
  logic            rd_burst_finish;
  logic            wr_burst_req;
  logic [B-1:0]    wr_burst_len;
  logic [A-1:0]    wr_burst_addr;
  logic            wr_burst_data_req;
  logic            wr_burst_finish;
  logic [D-1:0]    wr_burst_data;
  logic [1:0]      grant_id;
  logic            len_err;

  mem_burst_arbiter #(
    .MEM_DATA_BITS (D),
    .ADDR_BITS     (A),
    .BUSRT_BITS    (B),
    .RD_CH         (RD),
    .WR_CH         (WR)
  ) dut (
    .mem_clk                (mem_clk),
    .rst_n                  (rst_n),
    .ch_rd_burst_req        (ch_rd_burst_req),
    .ch_rd_burst_len        (ch_rd_burst_len),
    .ch_rd_burst_addr       (ch_rd_burst_addr),
    .ch_rd_burst_data_valid (ch_rd_burst_data_valid),
    .ch_rd_burst_data       (ch_rd_burst_data),
    .ch_rd_burst_finish     (ch_rd_burst_finish),
    .ch_wr_burst_req        (ch_wr_burst_req),
    .ch_wr_burst_len        (ch_wr_burst_len),
    .ch_wr_burst_addr       (ch_wr_burst_addr),
    .ch_wr_burst_data_req   (ch_wr_burst_data_req),
    .ch_wr_burst_data       (ch_wr_burst_data),
    .ch_wr_burst_finish     (ch_wr_burst_finish),
    .rd_burst_req           (rd_burst_req),
    .rd_burst_len           (rd_burst_len),
    .rd_burst_addr          (rd_burst_addr),
    .rd_burst_data_valid    (rd_burst_data_valid),
    .rd_burst_data          (rd_burst_data),
    .rd_burst_finish        (rd_burst_finish),
    .wr_burst_req           (wr_burst_req),
    .wr_burst_len           (wr_burst_len),
    .wr_burst_addr          (wr_burst_addr),
    .wr_burst_data_req      (wr_burst_data_req),
    .wr_burst_finish        (wr_burst_finish),
    .wr_burst_data          (wr_burst_data),
    .grant_id               (grant_id),
    .len_err                (len_err)
  );

  always #5 mem_clk = ~mem_clk;

  // Reference model: who is requesting, what they asked for, last grant, sticky error.
  logic [N-1:0] req_m;
  int           len_m  [N];
  logic [A-1:0] addr_m [N];
  logic [D-1:0] wdat_m [WR];
  int           last_m;
  bit           err_m;
  int           total;
  int           bad;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_expect(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic raise(input int c, input int len, input logic [A-1:0] addr);
    logic [D-1:0] wd;
    req_m[c]  = 1'b1;
    len_m[c]  = len;
    addr_m[c] = addr;
    if (c < RD) begin
      ch_rd_burst_req[c]            = 1'b1;
      ch_rd_burst_len[c*B +: B]     = B'(len);
      ch_rd_burst_addr[c*A +: A]    = addr;
    end else begin
      wd                                = {$urandom, $urandom};
      wdat_m[c-RD]                      = wd;
      ch_wr_burst_req[c-RD]             = 1'b1;
      ch_wr_burst_len[(c-RD)*B +: B]    = B'(len);
      ch_wr_burst_addr[(c-RD)*A +: A]   = addr;
      ch_wr_burst_data[(c-RD)*D +: D]   = wd;
    end
  endtask

  task automatic drop(input int c);
    req_m[c] = 1'b0;
    if (c < RD) ch_rd_burst_req[c] = 1'b0;
    else        ch_wr_burst_req[c-RD] = 1'b0;
  endtask

  task automatic raise_rand(input int c);
    raise(c, $urandom_range(1, 20), A'($urandom));
  endtask

  // err_mode: 0 exact beats, 1 random short burst, 2 always one beat short.
  task automatic serve_one(input int lat_exp, input bit reraise, input int err_mode);
    int exp_g, waited, beats, got, guard, w;
    bit is_rd, v;
    logic [RD-1:0] exp_rv;
    logic [WR-1:0] exp_wv;
    exp_g  = rr_expect(req_m, last_m);
    waited = 0;
    do begin
      @(negedge mem_clk);
      rd_burst_data_valid = 1'b0;
      wr_burst_data_req   = 1'b0;
      waited++;
    end while (!(rd_burst_req || wr_burst_req) && waited < 8);
    check_val("grant_latency", waited, lat_exp);
    if (!(rd_burst_req || wr_burst_req)) return;
    check_val("grant_id", grant_id, exp_g);
    last_m = exp_g;
    is_rd  = (exp_g < RD);
    w      = exp_g - RD;
    check_val("req_dir", {rd_burst_req, wr_burst_req}, is_rd ? 2'b10 : 2'b01);
    check_val("burst_len", is_rd ? rd_burst_len : wr_burst_len, len_m[exp_g]);
    check_val("burst_addr", is_rd ? rd_burst_addr : wr_burst_addr, addr_m[exp_g]);
    beats = len_m[exp_g];
    if (beats > 1 && (err_mode == 2 || (err_mode == 1 && $urandom_range(0, 3) == 0))) beats--;
    got   = 0;
    guard = 0;
    while (got < beats && guard < 400) begin
      v      = ($urandom_range(0, 3) != 0);
      exp_rv = '0;
      exp_wv = '0;
      if (is_rd) begin
        rd_burst_data_valid = v;
        rd_burst_data       = {$urandom, $urandom};
        if (v) exp_rv[exp_g] = 1'b1;
      end else begin
        wr_burst_data_req = v;
        if (v) exp_wv[w] = 1'b1;
      end
      #1;
      check_val("rd_valid_steer", ch_rd_burst_data_valid, exp_rv);
      check_val("wr_req_steer", ch_wr_burst_data_req, exp_wv);
      if (is_rd) check_val("rd_data_bcast", ch_rd_burst_data, rd_burst_data);
      else       check_val("wr_data_mux", wr_burst_data, wdat_m[w]);
      if (v) got++;
      guard++;
      @(negedge mem_clk);
    end
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;
    exp_rv = '0;
    exp_wv = '0;
    if (is_rd) begin
      rd_burst_finish = 1'b1;
      exp_rv[exp_g]   = 1'b1;
    end else begin
      wr_burst_finish = 1'b1;
      exp_wv[w]       = 1'b1;
    end
    #1;
    check_val("rd_finish_steer", ch_rd_burst_finish, exp_rv);
    check_val("wr_finish_steer", ch_wr_burst_finish, exp_wv);
    check_val("len_stable", is_rd ? rd_burst_len : wr_burst_len, len_m[exp_g]);
    @(negedge mem_clk);
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    check_val("req_drop", {rd_burst_req, wr_burst_req}, 2'b00);
    if (got != len_m[exp_g]) err_m = 1'b1;
    check_val("len_err", len_err, err_m);
    $display("burst ch=%0d %s len=%0d beats=%0d len_err=%0d", exp_g, is_rd ? "rd" : "wr",
             len_m[exp_g], got, len_err);
    drop(exp_g);
    if (reraise) begin
      raise_rand(exp_g);
    end else begin
      for (int c = 0; c < N; c++) begin
        if (!req_m[c] && $urandom_range(0, 2) == 0) raise_rand(c);
      end
      if (req_m == '0) raise_rand($urandom_range(0, N-1));
    end
    // Controller noise during GAP must not reach any channel.
    rd_burst_data_valid = 1'($urandom_range(0, 1));
    wr_burst_data_req   = 1'($urandom_range(0, 1));
    #1;
    check_val("gap_quiet_rd", ch_rd_burst_data_valid, '0);
    check_val("gap_quiet_wr", ch_wr_burst_data_req, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    req_m = '0;
    err_m = 1'b0;
    last_m = N - 1;
    ch_rd_burst_req = '0; ch_rd_burst_len = '0; ch_rd_burst_addr = '0;
    ch_wr_burst_req = '0; ch_wr_burst_len = '0; ch_wr_burst_addr = '0;
    ch_wr_burst_data = '0;
    rd_burst_data_valid = 1'b0; rd_burst_data = '0; rd_burst_finish = 1'b0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    for (int i = 0; i < N; i++) begin
      len_m[i]  = 0;
      addr_m[i] = '0;
    end
    for (int i = 0; i < WR; i++) wdat_m[i] = '0;

    repeat (3) @(negedge mem_clk);
    check_val("rst_rd_req", rd_burst_req, 1'b0);
    check_val("rst_wr_req", wr_burst_req, 1'b0);
    check_val("rst_grant", grant_id, 2'd0);
    check_val("rst_len_err", len_err, 1'b0);
    check_val("rst_rd_len", rd_burst_len, '0);
    rst_n = 1'b1;

    // Spurious controller activity in IDLE.
    @(negedge mem_clk);
    rd_burst_data_valid = 1'b1;
    wr_burst_data_req   = 1'b1;
    rd_burst_finish     = 1'b1;
    #1;
    check_val("idle_rd_valid", ch_rd_burst_data_valid, '0);
    check_val("idle_wr_req", ch_wr_burst_data_req, '0);
    check_val("idle_rd_fin", ch_rd_burst_finish, '0);
    check_val("idle_wr_data", wr_burst_data, '0);
    @(negedge mem_clk);
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;
    rd_burst_finish     = 1'b0;
    check_val("idle_no_grant", {rd_burst_req, wr_burst_req}, 2'b00);
    check_val("idle_len_err", len_err, 1'b0);

    // All four requesters from reset, channels re-request immediately.
    raise(0, 12, 25'h0000200);
    raise(1, 64, 25'h0001000);
    raise_rand(2);
    raise(3, 16, 25'h0123456);
    serve_one(1, 1'b1, 0);
    for (int i = 0; i < 4; i++) serve_one(2, 1'b1, 0);

    // Forced short burst, then random traffic with occasional short bursts.
    serve_one(2, 1'b0, 2);
    for (int i = 0; i < 30; i++) serve_one(2, 1'b0, 1);

    // Quiesce, then reset in the middle of a write burst.
    for (int c = 0; c < N; c++) drop(c);
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;
    repeat (3) @(negedge mem_clk);
    raise(3, 64, 25'h0040000);
    @(negedge mem_clk);
    check_val("mid_rst_grant", {wr_burst_req, grant_id}, {1'b1, 2'd3});
    wr_burst_data_req = 1'b1;
    repeat (10) @(negedge mem_clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_wr_req", wr_burst_req, 1'b0);
    check_val("arst_rd_req", rd_burst_req, 1'b0);
    check_val("arst_grant", grant_id, 2'd0);
    check_val("arst_len_err", len_err, 1'b0);
    check_val("arst_wr_steer", ch_wr_burst_data_req, '0);
    check_val("arst_wr_data", wr_burst_data, '0);
    check_val("arst_wr_len", wr_burst_len, '0);
    check_val("arst_wr_addr", wr_burst_addr, '0);
    wr_burst_data_req = 1'b0;
    drop(3);
    err_m  = 1'b0;
    last_m = N - 1;
    @(negedge mem_clk);
    rst_n = 1'b1;
    raise_rand(2);
    raise_rand(3);
    raise_rand(0);
    serve_one(1, 1'b0, 0);
    serve_one(2, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
